// File: rtl/bluetooth_response.sv
// UART packet receiver for a Bluetooth module: HEADER, 8 payload bytes and a checksum byte.
// Optional checksum verification is enabled by defining BLUETOOTH_RESP_CHECKSUM_EN.
module bluetooth_response #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_bluetooth,
    output logic [63:0] resp_bluetooth_data,
    output logic        resp_bluetooth_valid,
    output logic        resp_bluetooth_err,
    output logic        resp_bluetooth_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, DONE} pkt_state_t;

    rx_state_t        rx_state;
    pkt_state_t       pkt_state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_strobe;
    logic             frame_err;
    logic [3:0]       byte_idx;
    logic [63:0]      shift_reg;
`ifdef BLUETOOTH_RESP_CHECKSUM_EN
    logic [7:0]       acc;
`endif

    // Byte receiver; rx_prev lets a held-low line (break) avoid retriggering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            rx_shift    <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_meta     <= rx_bluetooth;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_CNT) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == FULL_CNT) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync)
                            byte_strobe <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Packet assembler; framing errors are only reported once a packet has started.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_state            <= HUNT;
            byte_idx             <= '0;
            shift_reg            <= '0;
            resp_bluetooth_data  <= '0;
            resp_bluetooth_valid <= 1'b0;
            resp_bluetooth_err   <= 1'b0;
            resp_bluetooth_busy  <= 1'b0;
`ifdef BLUETOOTH_RESP_CHECKSUM_EN
            acc                  <= '0;
`endif
        end else begin
            resp_bluetooth_valid <= 1'b0;
            resp_bluetooth_err   <= 1'b0;
            case (pkt_state)
                HUNT: begin
                    resp_bluetooth_busy <= 1'b0;
                    if (byte_strobe && rx_shift == HEADER) begin
                        byte_idx            <= '0;
`ifdef BLUETOOTH_RESP_CHECKSUM_EN
                        acc                 <= '0;
`endif
                        pkt_state           <= PAYLOAD;
                        resp_bluetooth_busy <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (frame_err) begin
                        resp_bluetooth_err  <= 1'b1;
                        resp_bluetooth_busy <= 1'b0;
                        pkt_state           <= HUNT;
                    end else if (byte_idx == 4'd8) begin
                        pkt_state <= CHECK;
                    end else if (byte_strobe) begin
                        shift_reg <= {shift_reg[55:0], rx_shift};
`ifdef BLUETOOTH_RESP_CHECKSUM_EN
                        acc       <= acc ^ rx_shift;
`endif
                        byte_idx  <= byte_idx + 1'b1;
                    end
                end
                CHECK: begin
                    if (frame_err) begin
                        resp_bluetooth_err  <= 1'b1;
                        resp_bluetooth_busy <= 1'b0;
                        pkt_state           <= HUNT;
                    end else if (byte_strobe) begin
`ifdef BLUETOOTH_RESP_CHECKSUM_EN
                        if (rx_shift == acc) begin
                            pkt_state <= DONE;
                        end else begin
                            resp_bluetooth_err  <= 1'b1;
                            resp_bluetooth_busy <= 1'b0;
                            pkt_state           <= HUNT;
                        end
`else
                        pkt_state <= DONE;
`endif
                    end
                end
                DONE: begin
                    resp_bluetooth_data  <= shift_reg;
                    resp_bluetooth_valid <= 1'b1;
                    resp_bluetooth_busy  <= 1'b0;
                    pkt_state            <= HUNT;
                end
                default: pkt_state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_bluetooth_response.sv
// Directed bench for bluetooth_response; uses a short bit period so whole packets stay cheap.
module tb_bluetooth_response;

    localparam int         CLKS   = 16;
    localparam logic [7:0] HEADER = 8'hAA;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [63:0] data;
    logic        valid;
    logic        err;
    logic        busy;

    int tests_run     = 0;
    int tests_failed  = 0;
    int valid_total   = 0;
    int err_total     = 0;
    int overlap_total = 0;
    int v0;
    int e0;

    bluetooth_response #(.CLKS_PER_BIT(CLKS), .HEADER(HEADER)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_bluetooth         (rx),
        .resp_bluetooth_data  (data),
        .resp_bluetooth_valid (valid),
        .resp_bluetooth_err   (err),
        .resp_bluetooth_busy  (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid) valid_total++;
        if (err) err_total++;
        if (valid && err) overlap_total++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(CLKS);
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        rx = 1'b1;
        wait_clks(CLKS);
    endtask

    task automatic send_packet(input logic [63:0] payload, input logic [7:0] cs);
        apply_stimulus(HEADER, 1'b1);
        for (int i = 0; i < 8; i++) apply_stimulus(payload[63-8*i -: 8], 1'b1);
        apply_stimulus(cs, 1'b1);
    endtask

    task automatic glitch();
        rx = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        wait_clks(CLKS);
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        wait_clks(4);
        check_output("reset_data", data, 64'h0);
        check_output("reset_valid", {63'b0, valid}, 64'h0);
        check_output("reset_err", {63'b0, err}, 64'h0);
        check_output("reset_busy", {63'b0, busy}, 64'h0);
        rst = 1'b1;
        wait_clks(4);

        // Basic good packet
        v0 = valid_total; e0 = err_total;
        apply_stimulus(HEADER, 1'b1);
        check_output("busy_after_header", {63'b0, busy}, 64'h1);
        for (int i = 1; i <= 8; i++) apply_stimulus(8'(i), 1'b1);
        apply_stimulus(8'h08, 1'b1);
        wait_clks(4);
        check_output("t1_valid_cnt", 64'(valid_total - v0), 64'd1);
        check_output("t1_err_cnt", 64'(err_total - e0), 64'd0);
        check_output("t1_data", data, 64'h0102030405060708);
        check_output("t1_busy_idle", {63'b0, busy}, 64'h0);

        // Wrong checksum (correct would be 88)
        v0 = valid_total; e0 = err_total;
        send_packet(64'h1122334455667788, 8'h89);
        wait_clks(4);
`ifdef BLUETOOTH_RESP_CHECKSUM_EN
        check_output("t2_valid_cnt", 64'(valid_total - v0), 64'd0);
        check_output("t2_err_cnt", 64'(err_total - e0), 64'd1);
        check_output("t2_data", data, 64'h0102030405060708);
`else
        check_output("t2_valid_cnt", 64'(valid_total - v0), 64'd1);
        check_output("t2_err_cnt", 64'(err_total - e0), 64'd0);
        check_output("t2_data", data, 64'h1122334455667788);
`endif

        // Leading junk before the header
        v0 = valid_total; e0 = err_total;
        apply_stimulus(8'h55, 1'b1);
        apply_stimulus(8'h13, 1'b1);
        send_packet(64'hA1B2C3D4E5F60718, 8'h08);
        wait_clks(4);
        check_output("t3_valid_cnt", 64'(valid_total - v0), 64'd1);
        check_output("t3_err_cnt", 64'(err_total - e0), 64'd0);
        check_output("t3_data", data, 64'hA1B2C3D4E5F60718);

        // Framing error on payload byte 4, then a clean packet
        v0 = valid_total; e0 = err_total;
        apply_stimulus(HEADER, 1'b1);
        for (int i = 1; i <= 3; i++) apply_stimulus(8'(i), 1'b1);
        apply_stimulus(8'h04, 1'b0);
        wait_clks(4);
        check_output("t4_err_cnt", 64'(err_total - e0), 64'd1);
        check_output("t4_valid_cnt", 64'(valid_total - v0), 64'd0);
        check_output("t4_busy", {63'b0, busy}, 64'h0);
        check_output("t4_data_kept", data, 64'hA1B2C3D4E5F60718);
        v0 = valid_total; e0 = err_total;
        send_packet(64'h0F1E2D3C4B5A6978, 8'h00);
        wait_clks(4);
        check_output("t4b_valid_cnt", 64'(valid_total - v0), 64'd1);
        check_output("t4b_data", data, 64'h0F1E2D3C4B5A6978);

        // Reset mid-packet after payload byte 5
        v0 = valid_total; e0 = err_total;
        apply_stimulus(HEADER, 1'b1);
        for (int i = 1; i <= 5; i++) apply_stimulus(8'(i), 1'b1);
        rst = 1'b0;
        wait_clks(1);
        rst = 1'b1;
        wait_clks(2);
        check_output("t5_data_cleared", data, 64'h0);
        check_output("t5_busy_cleared", {63'b0, busy}, 64'h0);
        send_packet(64'h0102030405060708, 8'h08);
        wait_clks(4);
        check_output("t5_valid_cnt", 64'(valid_total - v0), 64'd1);
        check_output("t5_err_cnt", 64'(err_total - e0), 64'd0);
        check_output("t5_data", data, 64'h0102030405060708);

        // Short low glitches, idle and between header and payload
        v0 = valid_total; e0 = err_total;
        glitch();
        wait_clks(3 * CLKS);
        check_output("t6_idle_valid", 64'(valid_total - v0), 64'd0);
        check_output("t6_idle_err", 64'(err_total - e0), 64'd0);
        check_output("t6_idle_busy", {63'b0, busy}, 64'h0);
        apply_stimulus(HEADER, 1'b1);
        glitch();
        for (int i = 0; i < 8; i++) apply_stimulus(8'(64'hDEADBEEF01234567 >> (56 - 8*i)), 1'b1);
        apply_stimulus(8'h22, 1'b1);
        wait_clks(4);
        check_output("t6_valid_cnt", 64'(valid_total - v0), 64'd1);
        check_output("t6_err_cnt", 64'(err_total - e0), 64'd0);
        check_output("t6_data", data, 64'hDEADBEEF01234567);

        check_output("no_valid_err_overlap", 64'(overlap_total), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
